// File: rtl/mutex_client_master.sv
// Avalon-MM master that takes and releases one hardware mutex word
// for a local requester, with backoff and an optional retry limit.
module mutex_client_master #(
  parameter logic [15:0] OWNER_ID       = 16'h0001,
  parameter logic [15:0] LOCK_VALUE     = 16'h0001,
  parameter int unsigned BACKOFF_CYCLES = 8,
  parameter int unsigned MAX_RETRIES    = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        lock_req,
  input  logic        unlock_req,
  output logic        lock_granted,
  output logic        lock_fail,
  output logic        busy,
  output logic        avm_address,
  output logic        avm_chipselect,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest
);

  typedef enum logic [2:0] {
    IDLE, ACQ_WR, ACQ_RD, BACKOFF, HELD, REL_WR
  } state_e;

  localparam logic [31:0] ACQ_WORD = {OWNER_ID, LOCK_VALUE};
  localparam logic [31:0] REL_WORD = {OWNER_ID, 16'h0000};
  localparam logic [7:0]  BO_LOAD  = 8'(BACKOFF_CYCLES);
  localparam logic [7:0]  RTY_MAX  = 8'(MAX_RETRIES);
  localparam bit          RTY_LIM  = (MAX_RETRIES != 0);

  state_e      state_q, state_d;
  logic [7:0]  retry_q, retry_d;
  logic [7:0]  bo_q, bo_d;
  logic [7:0]  retry_inc;
  logic        fail_q, fail_d;
  logic        cs_q, cs_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        gnt_q, gnt_d;
  logic        busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    bo_d      = bo_q;
    fail_d    = 1'b0;
    retry_inc = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
    unique case (state_q)
      IDLE: begin
        if (lock_req) state_d = ACQ_WR;
      end
      ACQ_WR: begin
        if (!avm_waitrequest) state_d = ACQ_RD;
      end
      ACQ_RD: begin
        if (!avm_waitrequest) begin
          if (avm_readdata == ACQ_WORD) begin
            state_d = HELD;
            retry_d = '0;
          end else if (RTY_LIM && retry_inc == RTY_MAX) begin
            state_d = IDLE;
            retry_d = '0;
            fail_d  = 1'b1;
          end else begin
            state_d = BACKOFF;
            retry_d = retry_inc;
            bo_d    = BO_LOAD;
          end
        end
      end
      BACKOFF: begin
        // last idle cycle is the one where the count is about to hit 0
        bo_d = bo_q - 8'd1;
        if (bo_q <= 8'd1) begin
          bo_d    = '0;
          state_d = ACQ_WR;
        end
      end
      HELD: begin
        if (unlock_req) state_d = REL_WR;
      end
      REL_WR: begin
        if (!avm_waitrequest) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cs_d    = 1'b0;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    wdata_d = '0;
    gnt_d   = 1'b0;
    busy_d  = 1'b0;
    unique case (state_d)
      ACQ_WR: begin
        cs_d    = 1'b1;
        wr_d    = 1'b1;
        wdata_d = ACQ_WORD;
        busy_d  = 1'b1;
      end
      ACQ_RD: begin
        cs_d   = 1'b1;
        rd_d   = 1'b1;
        busy_d = 1'b1;
      end
      BACKOFF: busy_d = 1'b1;
      HELD:    gnt_d  = 1'b1;
      REL_WR: begin
        cs_d    = 1'b1;
        wr_d    = 1'b1;
        wdata_d = REL_WORD;
        busy_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      retry_q <= '0;
      bo_q    <= '0;
      fail_q  <= 1'b0;
      cs_q    <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      gnt_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      retry_q <= retry_d;
      bo_q    <= bo_d;
      fail_q  <= fail_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
    end
  end

  assign avm_address    = 1'b0;
  assign avm_chipselect = cs_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_writedata  = wdata_q;
  assign lock_granted   = gnt_q;
  assign lock_fail      = fail_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_mutex_client_master.sv
// Bench for mutex_client_master: per-cycle expected bus traces built
// from acquire/release episodes, plus asynchronous reset sequences.
module tb_mutex_client_master;

  localparam logic [31:0] ACQ   = 32'h0001_0001;
  localparam logic [31:0] REL   = 32'h0001_0000;
  localparam logic [31:0] OTHER = 32'h0002_0005;
  localparam int BO = 4;
  localparam int MR = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        lock_req = 1'b0;
  logic        unlock_req = 1'b0;
  logic        lock_granted, lock_fail, busy;
  logic        avm_address, avm_chipselect, avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = '0;
  logic        avm_waitrequest = 1'b0;

  int checks = 0;
  int fails  = 0;
  int step   = 0;

  typedef struct {
    logic        lr, ur, wq;
    logic [31:0] rdd;
    logic        cs, rd, wr;
    logic [31:0] wd;
    logic        g, f, b;
  } vec_t;

  vec_t q[$];
  vec_t tbl[7];

  always #5 clk = ~clk;

  mutex_client_master #(
    .OWNER_ID(16'h0001), .LOCK_VALUE(16'h0001),
    .BACKOFF_CYCLES(BO), .MAX_RETRIES(MR)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .lock_req(lock_req), .unlock_req(unlock_req),
    .lock_granted(lock_granted), .lock_fail(lock_fail), .busy(busy),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .avm_waitrequest(avm_waitrequest)
  );

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [31:0] bad();
    return $urandom | 32'h0002_0000;
  endfunction

  function automatic vec_t mk(
    input logic lr, ur, wq, input logic [31:0] rdd,
    input logic cs, rd, wr, input logic [31:0] wd,
    input logic g, f, b);
    vec_t v;
    v.lr = lr; v.ur = ur; v.wq = wq; v.rdd = rdd;
    v.cs = cs; v.rd = rd; v.wr = wr; v.wd = wd;
    v.g = g; v.f = f; v.b = b;
    return v;
  endfunction

  task automatic check_out(input string tag,
    input logic cs, rd, wr, input logic [31:0] wd,
    input logic g, f, b);
    bit ok;
    ok = (avm_address === 1'b0) && (avm_chipselect === cs) &&
         (avm_read === rd) && (avm_write === wr) &&
         (lock_granted === g) && (lock_fail === f) &&
         (busy === b) && (!wr || avm_writedata === wd);
    checks++;
    if (!ok) begin
      fails++;
      $display("FAIL %s step %0d: got a=%b cs=%b rd=%b wr=%b wd=%h g=%b f=%b b=%b, want a=0 cs=%b rd=%b wr=%b wd=%h g=%b f=%b b=%b",
        tag, step, avm_address, avm_chipselect, avm_read, avm_write,
        avm_writedata, lock_granted, lock_fail, busy,
        cs, rd, wr, wd, g, f, b);
    end
    step++;
  endtask

  task automatic apply_vec(input string tag, input vec_t v);
    @(negedge clk);
    check_out(tag, v.cs, v.rd, v.wr, v.wd, v.g, v.f, v.b);
    lock_req        = v.lr;
    unlock_req      = v.ur;
    avm_waitrequest = v.wq;
    avm_readdata    = v.rdd;
  endtask

  task automatic run_q(input string tag);
    vec_t v;
    while (q.size() > 0) begin
      v = q.pop_front();
      apply_vec(tag, v);
    end
  endtask

  task automatic exp_idle();
    q.push_back(mk(1'b0, rb(), rb(), $urandom,
      1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic exp_wr(input logic wq, input logic [31:0] wd);
    q.push_back(mk(rb(), rb(), wq, $urandom,
      1'b1, 1'b0, 1'b1, wd, 1'b0, 1'b0, 1'b1));
  endtask

  task automatic exp_rd(input logic wq, input logic [31:0] rdd);
    q.push_back(mk(rb(), rb(), wq, rdd,
      1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1));
  endtask

  // attempts numbered from 1; attempt a succeeds once a > nfail
  task automatic acq_episode(input int nfail, input int wst,
    input int rst_, input bit rnd, input bit both, input int hold);
    int ws, rs;
    bit ok;
    q.push_back(mk(1'b1, both, rb(), $urandom,
      1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0));
    for (int a = 1; a <= MR; a++) begin
      ws = rnd ? int'($urandom_range(0, 3)) : wst;
      rs = rnd ? int'($urandom_range(0, 3)) : rst_;
      ok = (a > nfail);
      for (int s = 0; s < ws; s++) exp_wr(1'b1, ACQ);
      exp_wr(1'b0, ACQ);
      for (int s = 0; s < rs; s++) exp_rd(1'b1, ok ? bad() : ACQ);
      exp_rd(1'b0, ok ? ACQ : (rnd ? bad() : OTHER));
      if (ok) begin
        for (int h = 0; h < hold; h++)
          q.push_back(mk(rb(), 1'b0, rb(), $urandom,
            1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0));
        return;
      end
      if (a == MR) begin
        q.push_back(mk(1'b0, rb(), rb(), $urandom,
          1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0));
        return;
      end
      for (int s = 0; s < BO; s++)
        q.push_back(mk(rb(), rb(), rb(), $urandom,
          1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1));
    end
  endtask

  task automatic rel_episode(input int wst);
    q.push_back(mk(rb(), 1'b1, rb(), $urandom,
      1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0));
    for (int s = 0; s < wst; s++) exp_wr(1'b1, REL);
    exp_wr(1'b0, REL);
  endtask

  task automatic async_reset(input string tag);
    lock_req   = 1'b0;
    unlock_req = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_out(tag, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    int nf;
    tbl[0] = mk(1, 0, 0, '0,  0, 0, 0, '0,  0, 0, 0);
    tbl[1] = mk(0, 0, 0, '0,  1, 0, 1, ACQ, 0, 0, 1);
    tbl[2] = mk(0, 0, 0, ACQ, 1, 1, 0, '0,  0, 0, 1);
    tbl[3] = mk(0, 1, 0, '0,  0, 0, 0, '0,  1, 0, 0);
    tbl[4] = mk(0, 0, 0, '0,  1, 0, 1, REL, 0, 0, 1);
    tbl[5] = mk(0, 1, 0, '0,  0, 0, 0, '0,  0, 0, 0);
    tbl[6] = mk(0, 0, 0, '0,  0, 0, 0, '0,  0, 0, 0);

    repeat (2) @(negedge clk);
    check_out("reset", 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    for (int i = 0; i < 7; i++) apply_vec("table", tbl[i]);

    acq_episode(1, 0, 0, 1'b0, 1'b0, 1);
    rel_episode(0);
    exp_idle();
    run_q("held_other");

    acq_episode(3, 0, 0, 1'b0, 1'b0, 0);
    exp_idle();
    exp_idle();
    run_q("retry_limit");

    acq_episode(0, 5, 0, 1'b0, 1'b0, 1);
    rel_episode(0);
    exp_idle();
    run_q("wait5");

    acq_episode(0, 0, 0, 1'b0, 1'b1, 0);
    rel_episode(2);
    exp_idle();
    run_q("both_req");

    q.push_back(mk(1, 0, 0, '0, 0, 0, 0, '0, 0, 0, 0));
    exp_wr(1'b0, ACQ);
    exp_rd(1'b0, OTHER);
    q.push_back(mk(0, 0, 0, '0, 0, 0, 0, '0, 0, 0, 1));
    q.push_back(mk(0, 0, 0, '0, 0, 0, 0, '0, 0, 0, 1));
    run_q("pre_rst_bo");
    async_reset("rst_backoff");
    acq_episode(3, 0, 0, 1'b0, 1'b0, 0);
    exp_idle();
    run_q("post_rst_bo");

    q.push_back(mk(1, 0, 0, '0, 0, 0, 0, '0, 0, 0, 0));
    exp_wr(1'b0, ACQ);
    exp_rd(1'b1, ACQ);
    run_q("pre_rst_rd");
    async_reset("rst_acq_rd");
    acq_episode(0, 0, 0, 1'b0, 1'b0, 1);
    rel_episode(0);
    exp_idle();
    run_q("post_rst_rd");

    for (int n = 0; n < 200; n++) begin
      nf = int'($urandom_range(0, 3));
      acq_episode(nf, 0, 0, 1'b1, rb(), int'($urandom_range(0, 3)));
      if (nf < MR) rel_episode(int'($urandom_range(0, 3)));
      exp_idle();
      repeat ($urandom_range(0, 2)) exp_idle();
      run_q("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
      checks, fails);
    $finish;
  end

endmodule
